// File: rtl/preamble_inserter_if.sv
// AXI-stream style handshake bundle used on both sides of preamble_inserter.
interface preamble_inserter_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic [WIDTH-1:0] tdata;
    logic             tlast;
    logic             tvalid;
    logic             tready;

    modport master (
        output tdata,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tlast,
        input  tvalid,
        output tready
    );

endinterface

// File: rtl/preamble_inserter.sv
// Prepends a short+long training preamble from parameter ROMs to each stream packet.
// Define PREAMBLE_INSERTER_GAP_EN to append GAP_LEN zero samples after every packet.
module preamble_inserter #(
    parameter int unsigned                   WIDTH        = 32,
    parameter int unsigned                   SHORT_PERIOD = 16,
    parameter int unsigned                   SHORT_REPS   = 10,
    parameter int unsigned                   LONG_PERIOD  = 64,
    parameter int unsigned                   CP_LEN       = 32,
    parameter logic [WIDTH*SHORT_PERIOD-1:0] SHORT_SYM    = '0,
    parameter logic [WIDTH*LONG_PERIOD-1:0]  LONG_SYM     = '0,
    parameter int unsigned                   GAP_LEN      = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    preamble_inserter_if.slave  i_axis,
    preamble_inserter_if.master o_axis,
    output logic                underrun
);

    localparam int unsigned ShortLen = SHORT_PERIOD * SHORT_REPS;
    localparam int unsigned LongLen  = CP_LEN + 2 * LONG_PERIOD;
    localparam int unsigned CntMaxA  = (ShortLen > LongLen) ? ShortLen : LongLen;
    localparam int unsigned CntMax   = (CntMaxA > GAP_LEN) ? CntMaxA : GAP_LEN;
    localparam int unsigned CntW     = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam int unsigned ShortIdxW = (SHORT_PERIOD > 1) ? $clog2(SHORT_PERIOD) : 1;
    localparam int unsigned LongIdxW  = (LONG_PERIOD > 1) ? $clog2(LONG_PERIOD) : 1;

    localparam logic [CntW-1:0] CntOne    = CntW'(1);
    localparam logic [CntW-1:0] ShortLast = CntW'(ShortLen - 1);
    localparam logic [CntW-1:0] LongLast  = CntW'(LongLen - 1);
`ifdef PREAMBLE_INSERTER_GAP_EN
    localparam logic [CntW-1:0] GapLast   = CntW'(GAP_LEN - 1);
`endif

    typedef enum logic [2:0] {
        StIdle,
        StShort,
        StLong,
        StPayload,
        StGap
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            underrun_q, underrun_d;

    // Unpack the ROM parameters so the sample mux indexes by sample, not by bit.
    logic [WIDTH-1:0] short_rom [SHORT_PERIOD];
    logic [WIDTH-1:0] long_rom  [LONG_PERIOD];

    for (genvar k = 0; k < SHORT_PERIOD; k++) begin : g_short_rom
        assign short_rom[k] = SHORT_SYM[WIDTH*k +: WIDTH];
    end

    for (genvar k = 0; k < LONG_PERIOD; k++) begin : g_long_rom
        assign long_rom[k] = LONG_SYM[WIDTH*k +: WIDTH];
    end

    int unsigned          cnt_int;
    logic [ShortIdxW-1:0] short_idx;
    logic [LongIdxW-1:0]  long_idx;

    // Long section starts with the tail of the symbol as cyclic prefix.
    always_comb begin
        cnt_int   = 32'(cnt_q);
        short_idx = ShortIdxW'(cnt_int % SHORT_PERIOD);
        if (cnt_int < CP_LEN) begin
            long_idx = LongIdxW'(LONG_PERIOD - CP_LEN + cnt_int);
        end else begin
            long_idx = LongIdxW'((cnt_int - CP_LEN) % LONG_PERIOD);
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        underrun_d    = 1'b0;
        o_axis.tvalid = 1'b0;
        o_axis.tdata  = '0;
        o_axis.tlast  = 1'b0;
        i_axis.tready = 1'b0;

        case (state_q)
            StIdle: begin
                if (i_axis.tvalid) begin
                    state_d = StShort;
                    cnt_d   = '0;
                end
            end

            StShort: begin
                o_axis.tvalid = 1'b1;
                o_axis.tdata  = short_rom[short_idx];
                if (o_axis.tready) begin
                    if (cnt_q == ShortLast) begin
                        state_d = StLong;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
            end

            StLong: begin
                o_axis.tvalid = 1'b1;
                o_axis.tdata  = long_rom[long_idx];
                if (o_axis.tready) begin
                    if (cnt_q == LongLast) begin
                        state_d = StPayload;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
            end

            StPayload: begin
                o_axis.tvalid = i_axis.tvalid;
                o_axis.tdata  = i_axis.tdata;
                i_axis.tready = o_axis.tready;
`ifdef PREAMBLE_INSERTER_GAP_EN
                o_axis.tlast  = 1'b0;
`else
                o_axis.tlast  = i_axis.tlast;
`endif
                underrun_d    = o_axis.tready && !i_axis.tvalid;
                if (i_axis.tvalid && o_axis.tready && i_axis.tlast) begin
`ifdef PREAMBLE_INSERTER_GAP_EN
                    state_d = StGap;
`else
                    state_d = StIdle;
`endif
                    cnt_d   = '0;
                end
            end

`ifdef PREAMBLE_INSERTER_GAP_EN
            StGap: begin
                o_axis.tvalid = 1'b1;
                o_axis.tlast  = (cnt_q == GapLast);
                if (o_axis.tready) begin
                    if (cnt_q == GapLast) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
            end
`endif

            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // Clear beats any handshake in the same cycle; the beat in flight is lost.
        if (clear) begin
            state_d = StIdle;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            underrun_q <= underrun_d;
        end
    end

    assign underrun = underrun_q;

endmodule
